bit_serial_alu_ctrl: RTL

Initiator/driver for the single-bit ALU slice. It accepts WIDTH-bit operands and a 3-bit function code, then streams the operands LSB-first through one external bit slice, one bit per clock. Each cycle it feeds back the slice's carry and complement-carry outputs and reassembles the serial Rn stream into a WIDTH-bit result with flags. It sits between the datapath register file and the bit slice, and lets a single slice stand in for an N-bit ALU.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/bit_serial_alu_ctrl_if.sv | 27 ++
 rtl/serial_shift_reg.sv | 37 +++
 rtl/bit_serial_alu_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op codes, FSM encoding and helpers
// for the bit-serial ALU controller.
package alu_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XNOR  = 3'b100;
  localparam logic [2:0] OP_NOTA  = 3'b101;
  localparam logic [2:0] OP_PASSA = 3'b110;
  localparam logic [2:0] OP_NOTB  = 3'b111;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic logic is_arith(
    input logic [2:0] f
  );
    return (f == OP_ADD) || (f == OP_SUB);
  endfunction

endpackage

// File: rtl/bit_serial_alu_ctrl_if.sv
// Request/response bus of the serial ALU.
// master: start/opA/opB/func; slave: busy/done/result/flags.
interface bit_serial_alu_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [2:0]       func;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             zero;

  modport master (
    output start, opA, opB, func,
    input  busy, done, result,
    input  carry_out, zero
  );

  modport slave (
    input  start, opA, opB, func,
    output busy, done, result,
    output carry_out, zero
  );
endinterface

// File: rtl/serial_shift_reg.sv
// Right-shift register with load and shift enable.
// Ports: clk, rst_n (sync, low), load/din, shift/sin, q.
module serial_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic         sin,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);

  logic [W-1:0] sh_q;
  logic [W-1:0] sh_d;

  always_comb begin
    sh_d = sh_q;
    if (load) begin
      sh_d = din;
    end else if (shift) begin
      sh_d = {sin, sh_q[W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign q = sh_q;

endmodule

// File: rtl/bit_serial_alu_ctrl.sv
// Drives one external ALU bit slice LSB-first.
// Ports: clk, rst_n, bus (slave), sl_* slice link.
module bit_serial_alu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  bit_serial_alu_ctrl_if.slave bus,
  output logic       sl_An,
  output logic       sl_Bn,
  output logic [2:0] sl_func,
  output logic       sl_CinSOMA,
  output logic       sl_CinCOMP,
  input  logic       sl_CoutSOMA,
  input  logic       sl_CoutCOMP,
  input  logic       sl_Rn
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST =
    CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       func_q, func_d;
  logic             c_soma_q, c_soma_d;
  logic             c_comp_q, c_comp_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  logic             run;
  logic             accept;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic [WIDTH-1:0] r_next;
  logic             unused_hi;

  assign run    = (state_q == RUN);
  assign accept = (state_q == IDLE) && bus.start;

  // Result including the bit arriving this
  // cycle, so DONE already shows it.
  assign r_next = {sl_Rn, r_sh[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    func_d   = func_q;
    c_soma_d = c_soma_q;
    c_comp_d = c_comp_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = RUN;
          cnt_d    = '0;
          func_d   = bus.func;
          c_soma_d = 1'b0;
          c_comp_d = (bus.func == OP_SUB);
        end
      end
      RUN: begin
        c_soma_d = sl_CoutSOMA;
        c_comp_d = sl_CoutCOMP;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d  = DONE;
          result_d = r_next;
          carry_d  = is_arith(func_q)
                     ? sl_CoutSOMA : 1'b0;
          zero_d   = (r_next == '0);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      func_q   <= OP_ADD;
      c_soma_q <= 1'b0;
      c_comp_q <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      func_q   <= func_d;
      c_soma_q <= c_soma_d;
      c_comp_q <= c_comp_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  serial_shift_reg #(.W(WIDTH)) u_a_sh (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .shift (run),
    .sin   (1'b0),
    .din   (bus.opA),
    .q     (a_sh)
  );

  serial_shift_reg #(.W(WIDTH)) u_b_sh (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .shift (run),
    .sin   (1'b0),
    .din   (bus.opB),
    .q     (b_sh)
  );

  serial_shift_reg #(.W(WIDTH)) u_r_sh (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .shift (run),
    .sin   (sl_Rn),
    .din   ('0),
    .q     (r_sh)
  );

  // Only the LSB of the operand shifters
  // leaves this block.
  assign unused_hi = ^{a_sh[WIDTH-1:1],
                       b_sh[WIDTH-1:1]};

  assign sl_An      = run & a_sh[0];
  assign sl_Bn      = run & b_sh[0];
  assign sl_CinSOMA = run & c_soma_q;
  assign sl_CinCOMP = run & c_comp_q;
  assign sl_func    = func_q;

  assign bus.busy      = run;
  assign bus.done      = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.carry_out = carry_q;
  assign bus.zero      = zero_q;

endmodule
